// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB definitions: transfer/response encodings, arbiter FSM states,
// the dummy-master code and a one-hot to index helper.
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Master index width; code MST_DUMMY means "no master", so at most
    // three real masters fit.
    localparam int               MST_W     = 2;
    localparam int               MST_SLOTS = 4;
    localparam logic [MST_W-1:0] MST_DUMMY = 2'd3;

    // Index of the set bit of a one-hot vector, MST_DUMMY when empty.
    function automatic logic [MST_W-1:0] oh2idx(input logic [MST_SLOTS-1:0] oh);
        logic [MST_W-1:0] idx;
        idx = MST_DUMMY;
        for (int i = MST_SLOTS - 1; i >= 0; i--) begin
            if (oh[i]) idx = MST_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer,
// wrapping, with the pointer position itself searched last.
module ahb_rr_pick
    import ahb_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [MST_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o,
    output logic             vld_o
);

    // Walk ptr+1 .. ptr+N modulo N and take the first request seen.
    always_comb begin
        int idx;
        pick_o = '0;
        vld_o  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!vld_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with locked transfers and SPLIT
// masking. hgrant, hmaster and hmastlock are all registered.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MST = 3,
    parameter int DEF_MST = 0
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic               hready,
    input  logic [1:0]         hresp,
    input  logic [NUM_MST-1:0] hsplit,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MST_W-1:0]   hmaster,
    output logic               hmastlock
);

    localparam logic [NUM_MST-1:0] DEF_OH  = NUM_MST'(1) << DEF_MST;
    localparam logic [MST_W-1:0]   DEF_IDX = MST_W'(DEF_MST);

    arb_state_e         state_q, state_d;
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [MST_W-1:0]   master_q, master_d;
    logic               mastlock_q, mastlock_d;
    logic [NUM_MST-1:0] mask_q, mask_d;
    logic [MST_W-1:0]   ptr_q, ptr_d;
    logic [MST_W-1:0]   owner_q, owner_d;

    logic [MST_SLOTS-1:0] req_pad, lock_pad;
    logic                 owner_vld, lock_owner, cur_req, arb_pt;
    logic                 split_ev, kick, do_arb;
    logic [NUM_MST-1:0]   split_set, eligible, pick_oh, sel_oh;
    logic                 pick_vld, sel_lock;

    // Padding to the full index range lets the dummy code index safely (reads 0).
    assign req_pad  = MST_SLOTS'(hbusreq);
    assign lock_pad = MST_SLOTS'(hlock);

    assign owner_vld  = int'(owner_q) < NUM_MST;
    assign lock_owner = lock_pad[owner_q];
    assign cur_req    = req_pad[master_q];
    assign arb_pt     = hready && (htrans == HTRANS_IDLE || !cur_req);

    // A SPLIT response is signalled in its first (wait) cycle, hready=0.
    assign split_ev = (hresp == HRESP_SPLIT) && !hready && owner_vld;

    // One-hot of the master being split this cycle.
    always_comb begin
        split_set = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            split_set[i] = split_ev && (owner_q == MST_W'(i));
        end
    end

    // New split in the same cycle as a release for that master keeps it masked.
    assign mask_d   = (mask_q & ~hsplit) | split_set;
    assign eligible = hbusreq & ~mask_d;
    // Split master currently holds the grant: it must be moved off now.
    assign kick     = |(grant_q & split_set);

    ahb_rr_pick #(.N(NUM_MST)) u_pick (
        .req_i  (eligible),
        .ptr_i  (ptr_q),
        .pick_o (pick_oh),
        .vld_o  (pick_vld)
    );

    // Fall back to the default master only while it is not split-masked.
    assign sel_oh   = pick_vld ? pick_oh : (mask_d[DEF_MST] ? '0 : DEF_OH);
    assign sel_lock = |(sel_oh & hlock);

    // Next-state: arbitration decision, FSM transitions, address/data-phase tracking.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        owner_d    = owner_q;
        do_arb     = 1'b0;

        unique case (state_q)
            ST_ARB: do_arb = arb_pt || kick;
            ST_LOCKED: begin
                do_arb = (hready && !lock_owner) || kick;
                if (split_ev) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase

        if (do_arb) begin
            grant_d = sel_oh;
            state_d = sel_lock ? ST_LOCKED : ST_ARB;
            if (pick_vld) ptr_d = oh2idx(MST_SLOTS'(pick_oh));
        end

        if (hready) begin
            master_d   = oh2idx(MST_SLOTS'(grant_q));
            mastlock_d = |(grant_q & hlock);
            owner_d    = master_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q    <= ST_ARB;
            grant_q    <= DEF_OH;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            mask_q     <= '0;
            ptr_q      <= DEF_IDX;
            owner_q    <= DEF_IDX;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
        end
    end

    // Grant must never name more than one master.
    always_ff @(posedge hclk) begin
        if (hresetn) assert ($onehot0(grant_q));
    end

    assign hgrant    = grant_q;
    assign hmaster   = master_q;
    assign hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed vector table with hand-derived expectations,
// then randomized traffic against an integer-level reference model.
module tb_ahb_arbiter;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [2:0] hbusreq, hlock, hsplit, hgrant;
    logic [1:0] htrans, hresp, hmaster;
    logic       hready, hmastlock;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter #(.NUM_MST(3), .DEF_MST(0)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    typedef struct {
        logic       rst_n;
        logic [2:0] req, lock;
        logic [1:0] trans;
        logic       rdy;
        logic [1:0] resp;
        logic [2:0] split;
        logic [2:0] e_grant;
        logic [1:0] e_mst;
        logic       e_lock;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic [2:0] q, logic [2:0] l, logic [1:0] t,
                                logic y, logic [1:0] p, logic [2:0] s,
                                logic [2:0] eg, logic [1:0] em, logic el);
        vec_t v;
        v.rst_n = r; v.req = q; v.lock = l; v.trans = t; v.rdy = y;
        v.resp = p; v.split = s; v.e_grant = eg; v.e_mst = em; v.e_lock = el;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge hclk);
        hresetn = v.rst_n; hbusreq = v.req; hlock = v.lock; htrans = v.trans;
        hready = v.rdy; hresp = v.resp; hsplit = v.split;
        @(posedge hclk);
        #1;
    endtask

    // Reference model: grant as an integer index (-1 = none), master 3 = none.
    int m_grant, m_mst, m_mlock, m_locked, m_ptr, m_owner;
    bit m_mask[3];

    task automatic model_step(vec_t v);
        bit nmask[3];
        int split_m, win, target, i;
        bit cur_req, own_lock, kicked, rearb;
        int o_grant, o_mst;
        if (!v.rst_n) begin
            m_grant = 0; m_mst = 0; m_mlock = 0; m_locked = 0;
            m_ptr = 0; m_owner = 0;
            for (int k = 0; k < 3; k++) m_mask[k] = 0;
            return;
        end
        o_grant = m_grant;
        o_mst   = m_mst;
        split_m = (v.resp == 2'd3 && !v.rdy && m_owner < 3) ? m_owner : -1;
        for (int k = 0; k < 3; k++) nmask[k] = (m_mask[k] && !v.split[k]) || (k == split_m);
        win = -1;
        for (int k = 1; k <= 3; k++) begin
            i = (m_ptr + k) % 3;
            if (win < 0 && v.req[i] && !nmask[i]) win = i;
        end
        target   = (win >= 0) ? win : (nmask[0] ? -1 : 0);
        cur_req  = (m_mst < 3) && v.req[m_mst];
        own_lock = (m_owner < 3) && v.lock[m_owner];
        kicked   = (split_m >= 0) && (split_m == m_grant);
        if (m_locked) rearb = (v.rdy && !own_lock) || kicked;
        else          rearb = (v.rdy && (v.trans == 2'd0 || !cur_req)) || kicked;
        if (split_m >= 0) m_locked = 0;
        if (rearb) begin
            m_grant  = target;
            m_locked = (target >= 0) && v.lock[target];
            if (win >= 0) m_ptr = win;
        end
        if (v.rdy) begin
            m_owner = o_mst;
            m_mst   = (o_grant < 0) ? 3 : o_grant;
            m_mlock = (o_grant >= 0) && v.lock[o_grant];
        end
        for (int k = 0; k < 3; k++) m_mask[k] = nmask[k];
    endtask

    function automatic int grant_oh(int g);
        return (g < 0) ? 0 : (1 << g);
    endfunction

    initial begin
        vec_t v;
        hresetn = 0; hbusreq = 0; hlock = 0; htrans = 0;
        hready = 1; hresp = 0; hsplit = 0;

        // reset for two cycles
        tv.push_back(mk(0, 3'b000, 3'b000, 2, 1, 0, 3'b000, 3'b001, 0, 0));
        tv.push_back(mk(0, 3'b000, 3'b000, 2, 1, 0, 3'b000, 3'b001, 0, 0));
        // round robin, all requesting
        tv.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 0));
        tv.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b000, 3'b100, 1, 0));
        tv.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b000, 3'b001, 2, 0));
        // master1 locks; owner catches up to master1
        tv.push_back(mk(1, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 0, 0));
        tv.push_back(mk(1, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 1, 1));
        tv.push_back(mk(1, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 1, 1));
        // grant frozen for 4 cycles despite master0 requesting
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(1, 3'b011, 3'b010, 0, 1, 0, 3'b000, 3'b010, 1, 1));
        // lock drops -> master0 granted
        tv.push_back(mk(1, 3'b011, 3'b000, 0, 1, 0, 3'b000, 3'b001, 1, 0));
        // make master2 the data-phase owner
        tv.push_back(mk(1, 3'b100, 3'b000, 0, 1, 0, 3'b000, 3'b100, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 0, 1, 0, 3'b000, 3'b100, 2, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 0, 1, 0, 3'b000, 3'b100, 2, 0));
        // SPLIT on master2: grant leaves it, stays off until released
        tv.push_back(mk(1, 3'b100, 3'b000, 2, 0, 3, 3'b000, 3'b001, 2, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 0, 1, 0, 3'b000, 3'b001, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 0, 1, 0, 3'b100, 3'b100, 0, 0));
        // make master1 the owner, then split and release on the same cycle
        tv.push_back(mk(1, 3'b010, 3'b000, 0, 1, 0, 3'b000, 3'b010, 2, 0));
        tv.push_back(mk(1, 3'b010, 3'b000, 0, 1, 0, 3'b000, 3'b010, 1, 0));
        tv.push_back(mk(1, 3'b010, 3'b000, 0, 1, 0, 3'b000, 3'b010, 1, 0));
        tv.push_back(mk(1, 3'b010, 3'b000, 2, 0, 3, 3'b010, 3'b001, 1, 0));
        tv.push_back(mk(1, 3'b010, 3'b000, 0, 1, 0, 3'b000, 3'b001, 0, 0));
        tv.push_back(mk(1, 3'b010, 3'b000, 0, 1, 0, 3'b010, 3'b010, 0, 0));
        // split default master0, no requests -> no grant, dummy hmaster
        tv.push_back(mk(1, 3'b000, 3'b000, 0, 0, 3, 3'b000, 3'b010, 0, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b000, 1, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b000, 3, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 0, 1, 0, 3'b001, 3'b001, 3, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b001, 0, 0));
        // reset in the middle of a locked sequence
        tv.push_back(mk(1, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 0, 0));
        tv.push_back(mk(1, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 1, 1));
        tv.push_back(mk(0, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b001, 0, 0));
        tv.push_back(mk(1, 3'b011, 3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 0));

        foreach (tv[n]) begin
            apply(tv[n]);
            chk("vec.hgrant",    n, int'(hgrant),    int'(tv[n].e_grant));
            chk("vec.hmaster",   n, int'(hmaster),   int'(tv[n].e_mst));
            chk("vec.hmastlock", n, int'(hmastlock), int'(tv[n].e_lock));
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v.rst_n = (n == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            v.req   = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                v.lock[k]  = ($urandom_range(0, 3) == 0);
                v.split[k] = ($urandom_range(0, 7) == 0);
            end
            v.trans = 2'($urandom_range(0, 3));
            v.rdy   = ($urandom_range(0, 3) != 0);
            v.resp  = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            apply(v);
            model_step(v);
            chk("rnd.hgrant",    n, int'(hgrant),    grant_oh(m_grant));
            chk("rnd.hmaster",   n, int'(hmaster),   m_mst);
            chk("rnd.hmastlock", n, int'(hmastlock), m_mlock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
